// File: rtl/norm_pkg.sv
// Shared types and constants for the I/Q normalizer calibration controller.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int          OFS_MAX = 262143;
  localparam int          OFS_MIN = -262144;
  localparam logic [18:0] OFS_RST = 19'h3FFFF;

  // Channel index within shot_data: slice is [ch*IN_W +: IN_W].
  localparam int CH_I = 0;
  localparam int CH_Q = 1;

endpackage

// File: rtl/norm_min_tracker.sv
// Single-channel signed running minimum with clear; presents the negated,
// saturated minimum (including the sample being absorbed this cycle).
module norm_min_tracker
  import norm_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OFS_W = 19
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [OFS_W-1:0] ofs_o
);

  localparam logic signed [IN_W-1:0] IN_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W:0]   SAT_HI = (IN_W+1)'(OFS_MAX);
  localparam logic signed [IN_W:0]   SAT_LO = (IN_W+1)'(OFS_MIN);

  logic signed [IN_W-1:0] min_q, min_d, cand_s, data_s;
  logic signed [IN_W:0]   neg_s;

  assign data_s = data_i;

  // Candidate minimum, next minimum and negate-and-saturate of the candidate.
  always_comb begin
    cand_s = min_q;
    if (upd_i && (data_s < min_q)) begin
      cand_s = data_s;
    end else begin
      cand_s = min_q;
    end
    if (clr_i) begin
      min_d = IN_MAX;
    end else begin
      min_d = cand_s;
    end
    // One extra bit so that negating the most-negative input cannot wrap.
    neg_s = -{cand_s[IN_W-1], cand_s};
    if (neg_s > SAT_HI) begin
      ofs_o = SAT_HI[OFS_W-1:0];
    end else if (neg_s < SAT_LO) begin
      ofs_o = SAT_LO[OFS_W-1:0];
    end else begin
      ofs_o = neg_s[OFS_W-1:0];
    end
  end

  // Minimum register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q <= IN_MAX;
    end else begin
      min_q <= min_d;
    end
  end

endmodule

// File: rtl/norm_cal_ctrl.sv
// Calibration / admission controller for the I/Q normalizer feeding the NN core.
// Optional saturating drop counter enabled by macro NORM_CAL_CTRL_DROP_CNT_EN.
module norm_cal_ctrl
  import norm_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OFS_W     = 19,
  parameter int CAL_SHOTS = 1024,
  parameter int PIPE_LAT  = 7,
  parameter int DROP_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_start,
  input  logic              shot_valid,
  input  logic [2*IN_W-1:0] shot_data,
  input  logic              nn_done,
  output logic              norm_stb,
  output logic [OFS_W-1:0]  offset_i,
  output logic [OFS_W-1:0]  offset_q,
  output logic              nn_start,
  output logic              cal_busy,
  output logic              cal_done,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [15:0] CAL_N = 16'(CAL_SHOTS);
  localparam logic [7:0]  LAT_N = 8'(PIPE_LAT);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             outst_q, outst_d;
  logic [7:0]       lat_q, lat_d;
  logic             norm_stb_q, norm_stb_d;
  logic             nn_start_q, nn_start_d;
  logic             cal_done_q, cal_done_d;
  logic             cal_busy_q, cal_busy_d;
  logic [OFS_W-1:0] off_i_q, off_i_d, off_q_q, off_q_d;
  logic             trk_clr_s, trk_upd_s;
  logic [OFS_W-1:0] ofs_i_s, ofs_q_s;

  norm_min_tracker #(.IN_W(IN_W), .OFS_W(OFS_W)) u_min_i (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (trk_clr_s),
    .upd_i  (trk_upd_s),
    .data_i (shot_data[CH_I*IN_W +: IN_W]),
    .ofs_o  (ofs_i_s)
  );

  norm_min_tracker #(.IN_W(IN_W), .OFS_W(OFS_W)) u_min_q (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (trk_clr_s),
    .upd_i  (trk_upd_s),
    .data_i (shot_data[CH_Q*IN_W +: IN_W]),
    .ofs_o  (ofs_q_s)
  );

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q;
    lat_d      = (lat_q != 8'd0) ? (lat_q - 8'd1) : 8'd0;
    norm_stb_d = 1'b0;
    nn_start_d = (lat_q == 8'd1);
    cal_done_d = 1'b0;
    off_i_d    = off_i_q;
    off_q_d    = off_q_q;
    trk_clr_s  = 1'b0;
    trk_upd_s  = 1'b0;
    if (cal_start) begin
      // Restart wins over everything, including a pending nn_start.
      state_d    = CAL;
      cnt_d      = 16'd0;
      outst_d    = 1'b0;
      lat_d      = 8'd0;
      nn_start_d = 1'b0;
      trk_clr_s  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        CAL: begin
          if (shot_valid) begin
            trk_upd_s = 1'b1;
            if ((cnt_q + 16'd1) == CAL_N) begin
              off_i_d    = ofs_i_s;
              off_q_d    = ofs_q_s;
              cal_done_d = 1'b1;
              cnt_d      = 16'd0;
              state_d    = RUN;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        RUN: begin
          // nn_done frees the slot before the same-cycle shot is judged.
          if (shot_valid && (!outst_q || nn_done)) begin
            norm_stb_d = 1'b1;
            outst_d    = 1'b1;
            lat_d      = LAT_N;
          end else if (nn_done) begin
            outst_d = 1'b0;
          end else begin
            outst_d = outst_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    cal_busy_d = (state_d == CAL);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      outst_q    <= 1'b0;
      lat_q      <= 8'd0;
      norm_stb_q <= 1'b0;
      nn_start_q <= 1'b0;
      cal_done_q <= 1'b0;
      cal_busy_q <= 1'b0;
      off_i_q    <= OFS_W'(OFS_RST);
      off_q_q    <= OFS_W'(OFS_RST);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      lat_q      <= lat_d;
      norm_stb_q <= norm_stb_d;
      nn_start_q <= nn_start_d;
      cal_done_q <= cal_done_d;
      cal_busy_q <= cal_busy_d;
      off_i_q    <= off_i_d;
      off_q_q    <= off_q_d;
    end
  end

`ifdef NORM_CAL_CTRL_DROP_CNT_EN
  logic              drop_s;
  logic [DROP_W-1:0] drop_q, drop_d;

  // A drop is a RUN shot that finds the slot still occupied.
  always_comb begin
    drop_s = (state_q == RUN) && !cal_start && shot_valid && outst_q && !nn_done;
    if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end
  end

  // Saturating drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= {DROP_W{1'b0}};
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = {DROP_W{1'b0}};
`endif

  assign norm_stb = norm_stb_q;
  assign nn_start = nn_start_q;
  assign cal_done = cal_done_q;
  assign cal_busy = cal_busy_q;
  assign offset_i = off_i_q;
  assign offset_q = off_q_q;

endmodule

// File: tb/tb_norm_cal_ctrl.sv
// Scoreboard bench for norm_cal_ctrl: stimulus pushes expected pulses, a
// negedge monitor pops and checks them. Drop expectations follow NORM_CAL_CTRL_DROP_CNT_EN.
module tb_norm_cal_ctrl;

  localparam int K_DONE  = 0;
  localparam int K_STB   = 1;
  localparam int K_START = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [18:0] oi;
    logic [18:0] oq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cal_start;
  logic        shot_valid;
  logic [63:0] shot_data;
  logic        nn_done;
  logic        norm_stb;
  logic [18:0] offset_i;
  logic [18:0] offset_q;
  logic        nn_start;
  logic        cal_busy;
  logic        cal_done;
  logic [15:0] drop_count;

  exp_t        sb[$];
  int          cyc = 0;
  int          t_now;
  int          tests;
  int          fails;
  logic [15:0] exp_drop;
  logic [18:0] cur_oi;
  logic [18:0] cur_oq;

  norm_cal_ctrl #(
    .IN_W(32), .OFS_W(19), .CAL_SHOTS(4), .PIPE_LAT(7), .DROP_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cal_start  (cal_start),
    .shot_valid (shot_valid),
    .shot_data  (shot_data),
    .nn_done    (nn_done),
    .norm_stb   (norm_stb),
    .offset_i   (offset_i),
    .offset_q   (offset_q),
    .nn_start   (nn_start),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [18:0] oi, input logic [18:0] oq);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.oi   = oi;
    e.oq   = oq;
    sb.push_back(e);
  endtask

  task automatic drv(input logic cs, input logic sv, input logic [31:0] di,
                     input logic [31:0] dq, input logic nd);
    @(negedge clk);
    t_now      = cyc;
    cal_start  = cs;
    shot_valid = sv;
    shot_data  = {dq, di};
    nn_done    = nd;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst        = 1'b1;
    cal_start  = 1'b0;
    shot_valid = 1'b0;
    nn_done    = 1'b0;
    repeat (n) @(negedge clk);
    rst      = 1'b0;
    exp_drop = 16'd0;
    cur_oi   = 19'h3FFFF;
    cur_oq   = 19'h3FFFF;
  endtask

  task automatic note_drop();
`ifdef NORM_CAL_CTRL_DROP_CNT_EN
    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
  endtask

  task automatic mon_evt(input int k, input string nm);
    exp_t e;
    chk({nm, "_expected"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({nm, "_kind"}, k, e.kind);
      chk({nm, "_cycle"}, cyc, e.cyc);
      chk({nm, "_offset_i"}, 32'(offset_i), 32'(e.oi));
      chk({nm, "_offset_q"}, 32'(offset_q), 32'(e.oq));
    end
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cal_done) mon_evt(K_DONE, "cal_done");
      if (norm_stb) mon_evt(K_STB, "norm_stb");
      if (nn_start) mon_evt(K_START, "nn_start");
    end
  end

  task automatic chk_static(input string nm, input logic busy);
    chk({nm, "_cal_busy"}, 32'(cal_busy), 32'(busy));
    chk({nm, "_offset_i"}, 32'(offset_i), 32'(cur_oi));
    chk({nm, "_offset_q"}, 32'(offset_q), 32'(cur_oq));
    chk({nm, "_drop"}, 32'(drop_count), 32'(exp_drop));
  endtask

  initial begin
    rst = 1'b1; cal_start = 1'b0; shot_valid = 1'b0; shot_data = 64'd0; nn_done = 1'b0;
    tests = 0; fails = 0; exp_drop = 16'd0; cur_oi = 19'h3FFFF; cur_oq = 19'h3FFFF;
    do_reset(3);

    // Reset state, then shots in IDLE are ignored.
    idle(1);
    chk_static("reset", 1'b0);
    chk("reset_pulses", {29'd0, norm_stb, nn_start, cal_done}, 32'd0);
    repeat (3) drv(1'b0, 1'b1, 32'd11, 32'd22, 1'b0);
    idle(2);
    chk_static("idle_shots", 1'b0);

    // First calibration window.
    drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    drv(1'b0, 1'b1, 32'd500, -32'sd5, 1'b0);
    chk_static("cal1_busy", 1'b1);
    drv(1'b0, 1'b1, -32'sd1200, -32'sd5, 1'b0);
    drv(1'b0, 1'b1, 32'd30, 32'd9, 1'b0);
    drv(1'b0, 1'b1, 32'd7, 32'd0, 1'b0);
    push(K_DONE, t_now + 1, 19'd1200, 19'd5);
    idle(2);
    cur_oi = 19'd1200; cur_oq = 19'd5;
    chk_static("cal1_done", 1'b0);

    // RUN admission, drop and nn_done+shot in the same cycle.
    drv(1'b0, 1'b1, 32'd1, 32'd2, 1'b0);
    push(K_STB, t_now + 1, cur_oi, cur_oq);
    push(K_START, t_now + 8, cur_oi, cur_oq);
    idle(2);
    drv(1'b0, 1'b1, 32'd3, 32'd4, 1'b0);
    note_drop();
    idle(16);
    drv(1'b0, 1'b1, 32'd5, 32'd6, 1'b1);
    push(K_STB, t_now + 1, cur_oi, cur_oq);
    push(K_START, t_now + 8, cur_oi, cur_oq);
    chk_static("run_drop1", 1'b0);
    idle(9);
    drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    drv(1'b0, 1'b1, 32'd7, 32'd8, 1'b0);
    push(K_STB, t_now + 1, cur_oi, cur_oq);
    push(K_START, t_now + 8, cur_oi, cur_oq);
    drv(1'b0, 1'b1, 32'd9, 32'd10, 1'b0);
    note_drop();
    idle(8);
    drv(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    idle(1);
    chk_static("run_drop2", 1'b0);

    // cal_start two cycles before nn_start cancels it; its shot is not counted.
    drv(1'b0, 1'b1, 32'd1, 32'd1, 1'b0);
    push(K_STB, t_now + 1, cur_oi, cur_oq);
    idle(5);
    drv(1'b1, 1'b1, 32'd0, -32'sd50, 1'b0);
    drv(1'b0, 1'b1, -32'sd300000, 32'd10, 1'b0);
    drv(1'b0, 1'b1, 32'd5, 32'd50, 1'b0);
    chk_static("cal2_hold", 1'b1);
    drv(1'b0, 1'b1, 32'd100, 32'd1000, 1'b0);
    drv(1'b0, 1'b1, -32'sd7, 32'd20, 1'b0);
    push(K_DONE, t_now + 1, 19'h3FFFF, 19'h7FFF6);
    idle(3);
    cur_oi = 19'h3FFFF; cur_oq = 19'h7FFF6;
    chk_static("cal2_done", 1'b0);

    // Most-negative input and positive overflow of the negated minimum.
    drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    drv(1'b0, 1'b1, 32'h8000_0000, 32'd300000, 1'b0);
    drv(1'b0, 1'b1, 32'd1, 32'd400000, 1'b0);
    drv(1'b0, 1'b1, 32'd2, 32'd300001, 1'b0);
    drv(1'b0, 1'b1, 32'd3, 32'd500000, 1'b0);
    push(K_DONE, t_now + 1, 19'h3FFFF, 19'h40000);
    idle(2);
    cur_oi = 19'h3FFFF; cur_oq = 19'h40000;
    chk_static("cal3_done", 1'b0);

    // Reset in the middle of a calibration window.
    drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    drv(1'b0, 1'b1, -32'sd50000, -32'sd50000, 1'b0);
    drv(1'b0, 1'b1, -32'sd50000, -32'sd50000, 1'b0);
    do_reset(2);
    idle(1);
    chk_static("mid_cal_rst", 1'b0);

    drv(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    drv(1'b0, 1'b1, -32'sd100, -32'sd1, 1'b0);
    repeat (3) drv(1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    push(K_DONE, t_now + 1, 19'd100, 19'd1);
    idle(2);
    cur_oi = 19'd100; cur_oq = 19'd1;
    chk_static("cal4_done", 1'b0);

    // Drop counter saturation.
    drv(1'b0, 1'b1, 32'd1, 32'd1, 1'b0);
    push(K_STB, t_now + 1, cur_oi, cur_oq);
    push(K_START, t_now + 8, cur_oi, cur_oq);
    repeat (65535) begin
      drv(1'b0, 1'b1, 32'd2, 32'd2, 1'b0);
      note_drop();
    end
    idle(1);
    chk_static("drop_65535", 1'b0);
    repeat (5) begin
      drv(1'b0, 1'b1, 32'd2, 32'd2, 1'b0);
      note_drop();
    end
    idle(1);
    chk_static("drop_65540", 1'b0);

    idle(10);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
